mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch requester and the
//  load/store data requester of the processor. Accepts one request at a time and issues it on
//  the memory port. Waits for the memory response, then returns it to the owning requester.
//  Data has priority; an anti-starvation counter guarantees fetch progress. A watchdog flags hung memory.
// PARAMETERS
//  MAX_DATA_RUN   4    consecutive data grants allowed while a fetch is pending
//  TIMEOUT_CYCLES 255  max cycles in ISSUE+WAIT before abort (1..255)
// PORTS
//  clock        in   1   system clock, all state updates on posedge
//  reset        in   1   asynchronous, active-low reset
//  if_req_valid in   1   fetch request valid
//  if_req_ready out  1   fetch request accepted when valid&ready
//  if_addr      in   32  fetch address
//  if_rsp_valid out  1   one-cycle pulse: fetch data valid
//  if_rsp_data  out  32  fetched instruction
//  d_req_valid  in   1   data request valid
//  d_req_ready  out  1   data request accepted when valid&ready
//  d_addr       in   32  data address
//  d_we         in   1   1=store, 0=load
//  d_wstrb      in   4   byte write enables (store only)
//  d_wdata      in   32  store data
//  d_rsp_valid  out  1   one-cycle pulse: load data / store ack
//  d_rsp_data   out  32  load data (0 for stores)
//  mem_req      out  1   memory request, held until mem_gnt
//  mem_gnt      in   1   memory accepted request this cycle
//  mem_addr     out  32  registered address
//  mem_we       out  1   registered write flag
//  mem_wstrb    out  4   registered strobes (4'b0 on fetch/load)
//  mem_wdata    out  32  registered write data
//  mem_rvalid   in   1   memory response (reads and write acks)
//  mem_rdata    in   32  memory read data
//  busy         out  1   state != IDLE
//  timeout_err  out  1   sticky watchdog error
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, all outputs 0, owner=NONE, run_cnt=0, wd_cnt=0,
//    timeout_err=0. Reset mid-transaction discards it; no rsp pulse is generated.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE grant (combinational readys, only in IDLE):
//    d_req_ready = d_req_valid is irrelevant; ready=1 unless fetch is forced.
//    fetch forced when if_req_valid && run_cnt==MAX_DATA_RUN.
//    if_req_ready=1 iff (!d_req_valid || forced).
//    At most one handshake per cycle. On handshake: latch addr/we/wstrb/wdata, set owner, go ISSUE.
//    Fetch and load latch we=0, wstrb=0.
//  - run_cnt: +1 on data grant while if_req_valid=1 (saturates at MAX_DATA_RUN).
//    Cleared on any fetch grant, or on a data grant with if_req_valid=0.
//  - ISSUE: mem_req=1, mem_* stable; on mem_gnt go WAIT. mem_rvalid ignored outside WAIT.
//  - WAIT: on mem_rvalid capture mem_rdata (forced 0 for stores) and go RESP.
//  - RESP: owner's rsp_valid=1 for exactly this cycle with captured data; readys=0; next IDLE.
//  - Min latency: handshake cycle N, mem_req N+1, (gnt N+1, rvalid N+2), rsp_valid N+3.
//    Back-to-back requests accepted every 4 cycles.
//  - Watchdog: wd_cnt clears in IDLE, +1 each cycle in ISSUE/WAIT.
//    When wd_cnt==TIMEOUT_CYCLES: go RESP with data 0, set timeout_err (held until reset), drop mem_req.
//  - Simultaneous mem_gnt and mem_rvalid in ISSUE: gnt taken, rvalid ignored. Memory must
//    return rvalid >=1 cycle after gnt.
// TESTING
//  1 Reset low mid-WAIT -> all outputs 0 next edge, no rsp pulse; release -> IDLE, ready high.
//  2 Lone fetch addr 0x100, gnt same cycle, rvalid+1 with 0x00500093 -> if_rsp_valid 3 cycles
//    after handshake, data 0x00500093, mem_wstrb=0.
//  3 Fetch and load valid together -> data granted first; fetch granted on the following IDLE.
//  4 d_req_valid held high for 6 reqs with if_req_valid high, MAX_DATA_RUN=4 -> grant order
//    D,D,D,D,F,D,D.
//  5 Store 0xDEADBEEF wstrb 4'b0011 addr 0x2004, gnt delayed 3 cycles -> mem_* stable throughout;
//    d_rsp_valid with data 0.
//  6 No mem_rvalid, TIMEOUT_CYCLES=8 -> rsp pulse data 0 after 8 ISSUE/WAIT cycles; timeout_err stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported memory.
// Data wins by default; a run counter forces a fetch grant after MAX_DATA_RUN data grants.
module mem_port_arbiter #(
    parameter int MAX_DATA_RUN   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,

    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        timeout_err
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

    state_t           state;
    owner_t           owner;
    mem_cmd_t         cmd_q;
    logic [RUN_W-1:0] run_cnt;
    logic [7:0]       wd_cnt;

    logic        forced;
    logic        idle_ok;
    logic        d_hs;
    logic        if_hs;
    logic [7:0]  wd_next;
    logic        wd_expire;
    logic        deliver;
    logic [31:0] deliver_data;

    always_comb begin
        forced       = if_req_valid && (run_cnt == RUN_W'(MAX_DATA_RUN));
        // Readys are gated by reset so nothing looks acceptable while held in reset.
        idle_ok      = (state == IDLE) && reset;
        d_req_ready  = idle_ok && !forced;
        if_req_ready = idle_ok && (!d_req_valid || forced);
        d_hs         = d_req_valid && d_req_ready;
        if_hs        = if_req_valid && if_req_ready;

        wd_next      = wd_cnt + 8'd1;
        wd_expire    = ((state == ISSUE) || (state == WAIT)) &&
                       (wd_next == 8'(TIMEOUT_CYCLES));

        // Watchdog expiry takes precedence over a response landing in the same cycle.
        deliver      = wd_expire || ((state == WAIT) && mem_rvalid);
        deliver_data = 32'd0;
        if (!wd_expire && !cmd_q.we)
            deliver_data = mem_rdata;
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = cmd_q.addr;
    assign mem_we    = cmd_q.we;
    assign mem_wstrb = cmd_q.wstrb;
    assign mem_wdata = cmd_q.wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            cmd_q        <= '0;
            run_cnt      <= '0;
            wd_cnt       <= '0;
            mem_req      <= 1'b0;
            timeout_err  <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (d_hs) begin
                        cmd_q.addr  <= d_addr;
                        cmd_q.we    <= d_we;
                        cmd_q.wstrb <= d_we ? d_wstrb : 4'b0;
                        cmd_q.wdata <= d_wdata;
                        owner       <= OWN_DATA;
                        mem_req     <= 1'b1;
                        state       <= ISSUE;
                        // Only a data grant that overtook a waiting fetch counts toward the run.
                        if (!if_req_valid)
                            run_cnt <= '0;
                        else if (run_cnt != RUN_W'(MAX_DATA_RUN))
                            run_cnt <= run_cnt + RUN_W'(1);
                    end else if (if_hs) begin
                        cmd_q.addr  <= if_addr;
                        cmd_q.we    <= 1'b0;
                        cmd_q.wstrb <= 4'b0;
                        cmd_q.wdata <= '0;
                        owner       <= OWN_FETCH;
                        mem_req     <= 1'b1;
                        state       <= ISSUE;
                        run_cnt     <= '0;
                    end
                end

                ISSUE: begin
                    wd_cnt <= wd_next;
                    if (!wd_expire && mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    wd_cnt <= wd_next;
                end

                RESP: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase

            if (deliver) begin
                state   <= RESP;
                mem_req <= 1'b0;
                if (wd_expire)
                    timeout_err <= 1'b1;
                if (owner == OWN_FETCH) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= deliver_data;
                end else if (owner == OWN_DATA) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= deliver_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, latency, priority, anti-starvation, store, watchdog.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // In an IDLE cycle with valids already driven: check which side handshakes, then clock it.
    task automatic grant(input string tag, input logic exp_fetch);
        #1;
        chk(tag, {30'd0, if_req_valid && if_req_ready, d_req_valid && d_req_ready},
            exp_fetch ? 32'd2 : 32'd1);
        step();
    endtask

    // Runs the memory side from the first ISSUE cycle through RESP and back to IDLE.
    task automatic serve(input string tag, input int gnt_dly, input logic noise,
                         input logic [31:0] rdata, input logic to_data, input logic [31:0] exp_rsp,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, ".req"},   mem_req, 1);
            chk({tag, ".addr"},  mem_addr, exp_addr);
            chk({tag, ".we"},    mem_we, exp_we);
            chk({tag, ".wstrb"}, mem_wstrb, exp_wstrb);
            chk({tag, ".wdata"}, mem_wdata, exp_wdata);
            mem_gnt    = (i == gnt_dly);
            mem_rvalid = noise;
            mem_rdata  = 32'hBAD0_BAD0;
            step();
        end
        mem_gnt = 1'b0;
        chk({tag, ".wait_req"},  mem_req, 0);
        chk({tag, ".wait_busy"}, busy, 1);
        chk({tag, ".wait_norsp"}, if_rsp_valid | d_rsp_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        chk({tag, ".if_rsp"}, if_rsp_valid, !to_data);
        chk({tag, ".d_rsp"},  d_rsp_valid, to_data);
        chk({tag, ".data"},   to_data ? d_rsp_data : if_rsp_data, exp_rsp);
        chk({tag, ".resp_rdy"}, if_req_ready | d_req_ready, 0);
        step();
        chk({tag, ".pulse_end"}, if_rsp_valid | d_rsp_valid, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    logic exp_order [7];

    initial begin
        // Reset state
        #2;
        chk("rst.busy", busy, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.rdy", {30'd0, if_req_ready, d_req_ready}, 0);
        chk("rst.err", timeout_err, 0);
        step();
        reset = 1'b1;
        step();
        chk("rst.rel_rdy", {30'd0, if_req_ready, d_req_ready}, 3);

        // Test 1: reset mid-WAIT discards the transaction
        if_req_valid = 1'b1;
        if_addr      = 32'h80;
        grant("t1.grant", 1'b1);
        if_req_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("t1.in_wait", {30'd0, busy, mem_req}, 32'd2);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        chk("t1.busy", busy, 0);
        chk("t1.addr", mem_addr, 0);
        chk("t1.rdy", {30'd0, if_req_ready, d_req_ready}, 0);
        step();
        chk("t1.norsp", if_rsp_valid | d_rsp_valid, 0);
        step();
        chk("t1.norsp2", if_rsp_valid | d_rsp_valid, 0);
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        step();
        chk("t1.idle", busy, 0);
        chk("t1.rdy_back", {30'd0, if_req_ready, d_req_ready}, 3);
        chk("t1.norsp3", if_rsp_valid | d_rsp_valid, 0);

        // Test 2: lone fetch, minimum latency
        if_req_valid = 1'b1;
        if_addr      = 32'h100;
        grant("t2.grant", 1'b1);
        if_req_valid = 1'b0;
        serve("t2", 0, 1'b0, 32'h0050_0093, 1'b0, 32'h0050_0093, 32'h100, 1'b0, 4'b0, 32'h0);

        // Test 3: simultaneous fetch and load -> data then fetch
        if_req_valid = 1'b1;
        if_addr      = 32'h104;
        d_req_valid  = 1'b1;
        d_addr       = 32'h1000;
        d_we         = 1'b0;
        d_wdata      = '0;
        grant("t3.first", 1'b0);
        d_req_valid = 1'b0;
        serve("t3.d", 0, 1'b0, 32'h1111_2222, 1'b1, 32'h1111_2222, 32'h1000, 1'b0, 4'b0, 32'h0);
        grant("t3.second", 1'b1);
        if_req_valid = 1'b0;
        serve("t3.f", 0, 1'b0, 32'h3333_4444, 1'b0, 32'h3333_4444, 32'h104, 1'b0, 4'b0, 32'h0);

        // Test 4: both held high -> D,D,D,D,F,D,D
        exp_order    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        if_req_valid = 1'b1;
        if_addr      = 32'h200;
        d_req_valid  = 1'b1;
        d_addr       = 32'h3000;
        for (int g = 0; g < 7; g++) begin
            grant($sformatf("t4.grant%0d", g), exp_order[g]);
            serve($sformatf("t4.x%0d", g), 0, 1'b0, 32'hA000_0000 + g, !exp_order[g],
                  32'hA000_0000 + g, exp_order[g] ? 32'h200 : 32'h3000, 1'b0, 4'b0, 32'h0);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;

        // Test 5: store with delayed grant; rvalid during ISSUE must be ignored
        d_req_valid = 1'b1;
        d_addr      = 32'h2004;
        d_we        = 1'b1;
        d_wstrb     = 4'b0011;
        d_wdata     = 32'hDEAD_BEEF;
        grant("t5.grant", 1'b0);
        d_req_valid = 1'b0;
        d_we        = 1'b0;
        d_wstrb     = '0;
        d_wdata     = '0;
        serve("t5", 3, 1'b1, 32'h5555_6666, 1'b1, 32'h0, 32'h2004, 1'b1, 4'b0011, 32'hDEAD_BEEF);

        // Test 6: fetch never granted -> watchdog after 8 ISSUE/WAIT cycles
        chk("t6.err_pre", timeout_err, 0);
        if_req_valid = 1'b1;
        if_addr      = 32'h300;
        mem_rdata    = 32'hFFFF_FFFF;
        grant("t6.grant", 1'b1);
        if_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t6.req%0d", c), mem_req, 1);
            chk($sformatf("t6.norsp%0d", c), if_rsp_valid, 0);
            chk($sformatf("t6.noerr%0d", c), timeout_err, 0);
            step();
        end
        chk("t6.rsp", if_rsp_valid, 1);
        chk("t6.data", if_rsp_data, 0);
        chk("t6.err", timeout_err, 1);
        chk("t6.req_drop", mem_req, 0);
        step();
        chk("t6.idle", busy, 0);
        chk("t6.pulse_end", if_rsp_valid, 0);
        mem_rdata = '0;
        if_req_valid = 1'b1;
        if_addr      = 32'h304;
        grant("t6.after", 1'b1);
        if_req_valid = 1'b0;
        serve("t6.ok", 0, 1'b0, 32'h7777_8888, 1'b0, 32'h7777_8888, 32'h304, 1'b0, 4'b0, 32'h0);
        chk("t6.err_sticky", timeout_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
